rv_plic_claim_agent: RTL and testbench

Hardware interrupt-handling agent for the target side of the PLIC. It watches one target's `irq` line and claims the pending source by reading that target's CC register over TL-UL as a host. It then hands the claimed ID to a local consumer via a valid/ready handshake and, once the consumer signals completion, writes the ID back to CC. It sits between a PLIC target output and an accelerator or DMA that services interrupts without a CPU.

---
 rtl/rv_plic_claim_agent_pkg.sv | 25 ++
 rtl/tlul_pkg.sv | 43 ++++
 rtl/tlul_cmd_intg_gen.sv | 47 ++++
 rtl/rv_plic_claim_agent.sv | 217 +++++++++++++++++++++
 tb/tb_rv_plic_claim_agent.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_plic_claim_agent_pkg.sv
// Shared types and constants for the PLIC claim agent.
// No logic and no latency.
// Not applicable: holds no flow-controlled state.
package rv_plic_claim_agent_pkg;

  // One state per phase of the claim / dispatch / complete sequence.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLAIM_REQ = 3'd1,
    CLAIM_RSP = 3'd2,
    DISPATCH  = 3'd3,
    WAIT_DONE = 3'd4,
    CMPL_REQ  = 3'd5,
    CMPL_RSP  = 3'd6
  } claim_state_e;

  // CC is a 32-bit register, so every access is a full 4-byte word.
  localparam int unsigned CcSizeLog2 = 2;

  // Event counters stick at all-ones instead of wrapping to zero.
  function automatic logic [15:0] sat_inc16(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types used by the claim agent: host request and device response.
// Pure type definitions; no timing of its own.
// Backpressure is carried by a_ready (device) and d_ready (host).
package tlul_pkg;

  localparam logic [2:0] PutFullData   = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get           = 3'h4;
  localparam logic [2:0] AccessAck     = 3'h0;
  localparam logic [2:0] AccessAckData = 3'h1;

  typedef struct packed {
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_cmd_intg_gen.sv
// Generates a_user command and data integrity from the request fields.
// Purely combinational, zero latency.
// No backpressure: follows the request fields directly.
module tlul_cmd_intg_gen (
  input  logic [31:0] a_address,
  input  logic [2:0]  a_opcode,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  output logic [6:0]  cmd_intg,
  output logic [6:0]  data_intg
);

  // Six Hamming-style check bits plus one overall parity bit. Each mask
  // selects a distinct subset of payload bits so a single flipped bit
  // changes a unique combination of check bits. An all-zero payload
  // yields an all-zero code, which keeps the idle bus at zero.
  localparam logic [6:0][63:0] IntgMask = {
    64'hFFFF_FFFF_FFFF_FFFF,
    64'hFFFF_FFFF_0000_0000,
    64'hFFFF_0000_FFFF_0000,
    64'hFF00_FF00_FF00_FF00,
    64'hF0F0_F0F0_F0F0_F0F0,
    64'hCCCC_CCCC_CCCC_CCCC,
    64'hAAAA_AAAA_AAAA_AAAA
  };

  function automatic logic [6:0] intg7(logic [63:0] payload);
    logic [6:0] code;
    code = '0;
    for (int i = 0; i < 7; i++) begin
      code[i] = ^(payload & IntgMask[i]);
    end
    return code;
  endfunction

  logic [63:0] cmd_payload;
  logic [63:0] data_payload;

  // Command integrity covers address, opcode and byte mask; data covers the write data.
  always_comb begin
    cmd_payload  = {25'd0, a_address, a_opcode, a_mask};
    data_payload = {32'd0, a_data};
    cmd_intg     = intg7(cmd_payload);
    data_intg    = intg7(data_payload);
  end

endmodule

// File: rtl/rv_plic_claim_agent.sv
// CPU-less PLIC target agent: claims via CC read, hands the ID to a consumer, completes via CC write.
// irq -> a_valid 1 cycle; CC read d_valid -> evt_valid 1 cycle; done -> completion a_valid 1 cycle.
// Request fields held until a_ready; evt_id held until evt_ready; responses bounded by RspTimeout.
module rv_plic_claim_agent
  import tlul_pkg::*;
  import rv_plic_claim_agent_pkg::*;
#(
  parameter logic [31:0] CcAddr     = 32'h0020_0004,
  parameter int unsigned SrcW       = 5,
  parameter logic [7:0]  SourceId   = 8'h00,
  parameter int unsigned RspTimeout = 1024
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  input  logic            irq_i,
  output tl_h2d_t         tl_o,
  input  tl_d2h_t         tl_i,
  output logic            evt_valid_o,
  output logic [SrcW-1:0] evt_id_o,
  input  logic            evt_ready_i,
  input  logic            done_i,
  output logic            busy_o,
  output logic            err_o,
  output logic [15:0]     claim_cnt_o,
  output logic [15:0]     spurious_cnt_o
);

  localparam int unsigned TmoW = $clog2(RspTimeout + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(RspTimeout - 1);

  claim_state_e    state_q, state_d;
  logic [SrcW-1:0] id_q;
  logic [TmoW-1:0] tmo_q;
  logic            tmo_hit;
  logic            in_rsp;
  logic            err_d, err_q;
  logic            latch_id, claim_inc, spur_inc;
  logic            d_ready;
  logic [15:0]     claim_cnt_q, spurious_cnt_q;

  // Registered A-channel request, held stable until the device takes it.
  logic            a_valid_q;
  logic [2:0]      a_opcode_q;
  logic [1:0]      a_size_q;
  logic [7:0]      a_source_q;
  logic [31:0]     a_address_q;
  logic [3:0]      a_mask_q;
  logic [31:0]     a_data_q;
  logic [6:0]      cmd_intg, data_intg;

  logic [SrcW-1:0] rsp_id;
  assign rsp_id = tl_i.d_data[SrcW-1:0];

  assign in_rsp  = (state_q == CLAIM_RSP) || (state_q == CMPL_RSP);
  assign tmo_hit = in_rsp && (tmo_q == TmoLast);

  // Next-state and per-cycle control; d_ready is high whenever a response may legally arrive.
  always_comb begin
    state_d   = state_q;
    err_d     = 1'b0;
    latch_id  = 1'b0;
    claim_inc = 1'b0;
    spur_inc  = 1'b0;
    d_ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Stale responses from an abandoned or reset-interrupted access are drained here.
        d_ready = 1'b1;
        if (irq_i && enable_i) state_d = CLAIM_REQ;
      end
      CLAIM_REQ: begin
        if (tl_i.a_ready) state_d = CLAIM_RSP;
      end
      CLAIM_RSP: begin
        d_ready = 1'b1;
        if (tl_i.d_valid) begin
          if (tl_i.d_error) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (rsp_id == '0) begin
            spur_inc = 1'b1;
            state_d  = IDLE;
          end else begin
            latch_id  = 1'b1;
            claim_inc = 1'b1;
            state_d   = DISPATCH;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DISPATCH: begin
        if (evt_ready_i) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_i) state_d = CMPL_REQ;
      end
      CMPL_REQ: begin
        if (tl_i.a_ready) state_d = CMPL_RSP;
      end
      CMPL_RSP: begin
        d_ready = 1'b1;
        if (tl_i.d_valid) begin
          err_d   = tl_i.d_error;
          state_d = IDLE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Response timeout: restarts on every entry to a response state, counts while waiting there.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else if (in_rsp && (state_d == state_q)) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end

  // Claimed ID, error pulse and saturating event counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q           <= '0;
      err_q          <= 1'b0;
      claim_cnt_q    <= '0;
      spurious_cnt_q <= '0;
    end else begin
      err_q <= err_d;
      if (latch_id)  id_q           <= rsp_id;
      if (claim_inc) claim_cnt_q    <= sat_inc16(claim_cnt_q);
      if (spur_inc)  spurious_cnt_q <= sat_inc16(spurious_cnt_q);
    end
  end

  // Request fields are loaded from the state being entered, so they appear one cycle
  // after the triggering event and re-load identical values while a_ready is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
    end else begin
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      if (state_d == CLAIM_REQ || state_d == CMPL_REQ) begin
        a_valid_q   <= 1'b1;
        a_opcode_q  <= (state_d == CLAIM_REQ) ? Get : PutFullData;
        a_size_q    <= 2'(CcSizeLog2);
        a_source_q  <= SourceId;
        a_address_q <= CcAddr;
        a_mask_q    <= 4'hF;
        a_data_q    <= (state_d == CMPL_REQ) ? 32'(id_q) : 32'd0;
      end
    end
  end

  tlul_cmd_intg_gen u_intg (
    .a_address (a_address_q),
    .a_opcode  (a_opcode_q),
    .a_mask    (a_mask_q),
    .a_data    (a_data_q),
    .cmd_intg  (cmd_intg),
    .data_intg (data_intg)
  );

  // Assemble the host request channel.
  always_comb begin
    tl_o                  = '0;
    tl_o.a_valid          = a_valid_q;
    tl_o.a_opcode         = a_opcode_q;
    tl_o.a_param          = 3'd0;
    tl_o.a_size           = a_size_q;
    tl_o.a_source         = a_source_q;
    tl_o.a_address        = a_address_q;
    tl_o.a_mask           = a_mask_q;
    tl_o.a_data           = a_data_q;
    tl_o.a_user.cmd_intg  = cmd_intg;
    tl_o.a_user.data_intg = data_intg;
    tl_o.d_ready          = d_ready;
  end

  assign evt_valid_o    = (state_q == DISPATCH);
  assign evt_id_o       = id_q;
  assign busy_o         = (state_q != IDLE);
  assign err_o          = err_q;
  assign claim_cnt_o    = claim_cnt_q;
  assign spurious_cnt_o = spurious_cnt_q;

  // Response fields the agent has no use for; integrity of responses is not checked.
  logic unused_rsp;
  assign unused_rsp = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                        tl_i.d_sink, tl_i.d_data[31:SrcW], tl_i.d_user};

endmodule

// File: tb/tb_rv_plic_claim_agent.sv
// Directed bench for rv_plic_claim_agent with a hand-driven TL-UL device.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Handshakes are counted on the falling edge, when all signals are stable.
module tb_rv_plic_claim_agent;
  import tlul_pkg::*;

  localparam logic [31:0] CcAddr = 32'h0020_0004;
  localparam int unsigned Tmo    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        irq = 1'b0;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;
  logic        evt_valid;
  logic [4:0]  evt_id;
  logic        evt_ready = 1'b0;
  logic        done = 1'b0;
  logic        busy;
  logic        err;
  logic [15:0] claim_cnt;
  logic [15:0] spurious_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int get_hs = 0;
  int put_hs = 0;

  always #5 clk = ~clk;

  rv_plic_claim_agent #(
    .CcAddr     (CcAddr),
    .SrcW       (5),
    .SourceId   (8'h00),
    .RspTimeout (Tmo)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .irq_i          (irq),
    .tl_o           (tl_o),
    .tl_i           (tl_i),
    .evt_valid_o    (evt_valid),
    .evt_id_o       (evt_id),
    .evt_ready_i    (evt_ready),
    .done_i         (done),
    .busy_o         (busy),
    .err_o          (err),
    .claim_cnt_o    (claim_cnt),
    .spurious_cnt_o (spurious_cnt)
  );

  always @(negedge clk) begin
    if (tl_o.a_valid && tl_i.a_ready) begin
      if (tl_o.a_opcode == Get) get_hs++;
      else                      put_hs++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Take the pending claim request and answer it with the given data/error.
  task automatic serve_claim(input logic [31:0] data, input logic error);
    irq            = 1'b0;
    tl_i.a_ready   = 1'b1;
    tick();
    tl_i.a_ready   = 1'b0;
    tl_i.d_valid   = 1'b1;
    tl_i.d_data    = data;
    tl_i.d_error   = error;
    tick();
    tl_i.d_valid   = 1'b0;
    tl_i.d_data    = 32'd0;
    tl_i.d_error   = 1'b0;
  endtask

  int n, g0, p0;
  logic [31:0] hold_addr;

  initial begin
    tl_i = '0;
    tick();
    tick();
    // Reset values.
    check("rst_a_valid", 32'(tl_o.a_valid), 32'd0);
    check("rst_a_addr", tl_o.a_address, 32'd0);
    check("rst_a_fields", {22'd0, tl_o.a_opcode, tl_o.a_size, tl_o.a_mask, tl_o.a_param}, 32'd0);
    check("rst_a_user", {18'd0, tl_o.a_user}, 32'd0);
    check("rst_d_ready", 32'(tl_o.d_ready), 32'd1);
    check("rst_outs", {27'd0, evt_valid, busy, err, 2'd0}, 32'd0);
    check("rst_evt_id", 32'(evt_id), 32'd0);
    check("rst_cnts", {claim_cnt, spurious_cnt}, 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    tick();

    // Basic flow.
    irq = 1'b1;
    evt_ready = 1'b1;
    tick();
    check("basic_a_valid", 32'(tl_o.a_valid), 32'd1);
    check("basic_get", 32'(tl_o.a_opcode), 32'(Get));
    check("basic_addr", tl_o.a_address, CcAddr);
    check("basic_size_mask", {24'd0, tl_o.a_size, 2'd0, tl_o.a_mask}, {24'd0, 2'd2, 2'd0, 4'hF});
    check("basic_busy", 32'(busy), 32'd1);
    serve_claim(32'h7, 1'b0);
    check("basic_evt_valid", 32'(evt_valid), 32'd1);
    check("basic_evt_id", 32'(evt_id), 32'd7);
    check("basic_claim_cnt", 32'(claim_cnt), 32'd1);
    check("basic_a_dropped", 32'(tl_o.a_valid), 32'd0);
    tick();
    evt_ready = 1'b0;
    check("basic_evt_taken", 32'(evt_valid), 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("cmpl_a_valid", 32'(tl_o.a_valid), 32'd1);
    check("cmpl_put", 32'(tl_o.a_opcode), 32'(PutFullData));
    check("cmpl_addr", tl_o.a_address, CcAddr);
    check("cmpl_data", tl_o.a_data, 32'd7);
    check("cmpl_mask", 32'(tl_o.a_mask), 32'hF);
    tl_i.a_ready = 1'b1;
    tick();
    tl_i.a_ready = 1'b0;
    check("cmpl_a_dropped", 32'(tl_o.a_valid), 32'd0);
    tl_i.d_valid = 1'b1;
    tick();
    tl_i.d_valid = 1'b0;
    check("cmpl_idle", {30'd0, busy, err}, 32'd0);
    check("basic_hs", get_hs * 256 + put_hs, 32'h101);

    // Spurious claim.
    irq = 1'b1;
    tick();
    serve_claim(32'h0, 1'b0);
    check("spur_no_evt", 32'(evt_valid), 32'd0);
    check("spur_idle", 32'(busy), 32'd0);
    check("spur_cnts", {claim_cnt, spurious_cnt}, {16'd1, 16'd1});
    tick();

    // Backpressure: a_ready low 5 cycles on both requests, evt_ready low 10 cycles.
    g0 = get_hs;
    p0 = put_hs;
    irq = 1'b1;
    tick();
    irq = 1'b0;
    hold_addr = tl_o.a_address;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_claim_hold", {tl_o.a_valid, 28'd0, tl_o.a_opcode}, {1'b1, 28'd0, Get});
      check("bp_claim_addr", tl_o.a_address, hold_addr);
    end
    serve_claim(32'hFFFF_FFE3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("bp_evt_hold", {evt_valid, 26'd0, evt_id}, {1'b1, 26'd0, 5'd3});
      tick();
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_cmpl_hold", {tl_o.a_valid, 31'd0} | tl_o.a_data, 32'h8000_0003);
      tick();
    end
    tl_i.a_ready = 1'b1;
    tick();
    tl_i.a_ready = 1'b0;
    tl_i.d_valid = 1'b1;
    tick();
    tl_i.d_valid = 1'b0;
    check("bp_hs", (get_hs - g0) * 256 + (put_hs - p0), 32'h101);
    check("bp_claim_cnt", 32'(claim_cnt), 32'd2);

    // Claim response with d_error.
    irq = 1'b1;
    tick();
    serve_claim(32'h5, 1'b1);
    check("derr_pulse", {29'd0, err, evt_valid, busy}, 32'h4);
    tick();
    check("derr_one_cycle", 32'(err), 32'd0);
    check("derr_cnts", {claim_cnt, spurious_cnt}, {16'd2, 16'd1});

    // Claim response timeout.
    irq = 1'b1;
    tick();
    irq = 1'b0;
    tl_i.a_ready = 1'b1;
    tick();
    tl_i.a_ready = 1'b0;
    n = 0;
    while (n < 3 * Tmo && !err) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, Tmo);
    check("tmo_idle", 32'(busy), 32'd0);
    // Late response arrives in IDLE and is simply absorbed.
    tl_i.d_valid = 1'b1;
    tl_i.d_data  = 32'h4;
    check("late_d_ready", 32'(tl_o.d_ready), 32'd1);
    tick();
    tl_i.d_valid = 1'b0;
    tl_i.d_data  = 32'd0;
    check("late_ignored", {29'd0, err, busy, evt_valid}, 32'd0);

    // Reset while waiting for done.
    p0 = put_hs;
    irq = 1'b1;
    evt_ready = 1'b1;
    tick();
    serve_claim(32'h9, 1'b0);
    tick();
    evt_ready = 1'b0;
    check("rstwd_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstwd_outs", {28'd0, busy, evt_valid, err, tl_o.a_valid}, 32'd0);
    check("rstwd_cnts", {claim_cnt, spurious_cnt}, 32'd0);
    check("rstwd_d_ready", 32'(tl_o.d_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("rstwd_no_write", {30'd0, tl_o.a_valid, busy}, 32'd0);
    tick();
    check("rstwd_put_hs", put_hs - p0, 32'd0);

    // Enable gating.
    enable = 1'b0;
    irq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("en_gated", {30'd0, tl_o.a_valid, busy}, 32'd0);
    end
    enable = 1'b1;
    tick();
    check("en_claim", 32'(tl_o.a_valid), 32'd1);
    serve_claim(32'h0, 1'b0);
    check("en_spur", 32'(spurious_cnt), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
